inst_fetch_queue: RTL

//  Parametrised fetch stage with a prefetch queue between inst SRAM and ID.

---
 rtl/inst_fetch_queue.sv | 106 ++++++++++
 1 files changed

// File: rtl/inst_fetch_queue.sv
// Fetch stage: issues sequential PCs to a 1-cycle inst SRAM and buffers {pc,inst}
// pairs in a small prefetch queue so ID back-pressure never drops an SRAM response.
module inst_fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter int          ADDR_W   = 32,
   parameter int          DATA_W   = 32,
   parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_br_e,
   input  logic [ADDR_W-1:0]          i_br_addr,
   output logic                       o_inst_sram_en,
   output logic [3:0]                 o_inst_sram_wen,
   output logic [ADDR_W-1:0]          o_inst_sram_addr,
   output logic [DATA_W-1:0]          o_inst_sram_wdata,
   input  logic [DATA_W-1:0]          i_inst_sram_rdata,
   output logic                       o_out_valid,
   input  logic                       i_out_ready,
   output logic [ADDR_W-1:0]          o_out_pc,
   output logic [DATA_W-1:0]          o_out_inst,
   output logic [$clog2(DEPTH):0]     o_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] r_inflight_pc;
   logic              r_inflight;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [CNT_W-1:0]  r_count;
   logic [ADDR_W-1:0] r_mem_pc   [DEPTH];
   logic [DATA_W-1:0] r_mem_inst [DEPTH];

   logic [CNT_W-1:0]  w_used;
   logic              w_issue;
   logic              w_push;
   logic              w_pop;
   logic              w_valid;

   // Credit counts the outstanding request so its response always has a slot.
   assign w_used  = r_count + {{PTR_W{1'b0}}, r_inflight};
   assign w_issue = !i_rst && !i_br_e && (w_used < CNT_W'(DEPTH));
   assign w_valid = (r_count != '0);
   assign w_push  = r_inflight && !i_br_e;
   assign w_pop   = w_valid && i_out_ready && !i_br_e;

   assign o_inst_sram_en    = w_issue;
   assign o_inst_sram_wen   = 4'b0000;
   assign o_inst_sram_addr  = r_pc;
   assign o_inst_sram_wdata = '0;
   assign o_out_valid       = w_valid;
   assign o_out_pc          = r_mem_pc[r_rd_ptr];
   assign o_out_inst        = r_mem_inst[r_rd_ptr];
   assign o_count           = r_count;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_pc          <= ADDR_W'(RESET_PC);
         r_inflight    <= 1'b0;
         r_inflight_pc <= '0;
         r_rd_ptr      <= '0;
         r_wr_ptr      <= '0;
         r_count       <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem_pc[i]   <= '0;
            r_mem_inst[i] <= '0;
         end
      end else if (i_br_e) begin
         // Redirect: drop queue contents and any response arriving this cycle.
         r_pc       <= i_br_addr;
         r_inflight <= 1'b0;
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_count    <= '0;
      end else begin
         r_inflight <= w_issue;
         if (w_issue) begin
            r_pc          <= r_pc + ADDR_W'(4);
            r_inflight_pc <= r_pc;
         end
         if (w_push) begin
            r_mem_pc[r_wr_ptr]   <= r_inflight_pc;
            r_mem_inst[r_wr_ptr] <= i_inst_sram_rdata;
            r_wr_ptr             <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + CNT_W'(1);
         end else if (!w_push && w_pop) begin
            r_count <= r_count - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         assert (!(w_push && (r_count == CNT_W'(DEPTH))));
      end
   end

endmodule
